// File: rtl/sme_host.sv
`timescale 1ns/1ps
// sme_host: buffers byte-wise string/pattern jobs, replays each to SME as
// one contiguous strobe burst and returns SME's verdict on a result port.
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_char/in_type/in_last : upstream job bytes
//   sme_chardata/sme_isstring/sme_ispattern   : registered SME drive
//   sme_valid/sme_match/sme_match_index       : SME result
//   res_valid/res_ready/res_match/res_index/res_timeout : result port
//   ovf  : pulse on in_last of a job that overflowed its buffer
//   busy : high outside IDLE
module sme_host #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  input  logic       in_type,
  input  logic       in_last,
  output logic [7:0] sme_chardata,
  output logic       sme_isstring,
  output logic       sme_ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_match_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout,
  output logic       ovf,
  output logic       busy
);

  localparam int LW = $clog2(STR_MAX + 1);
  localparam int IW = $clog2(STR_MAX);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [LW-1:0] STR_LIM = LW'(STR_MAX);
  localparam logic [LW-1:0] PAT_LIM = LW'(PAT_MAX);
  localparam logic [CW-1:0] TO_LIM  = CW'(TIMEOUT);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]    state_q, state_d;
  logic          type_q, type_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic          drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    char_q, char_d;
  logic          isstr_q, isstr_d;
  logic          ispat_q, ispat_d;
  logic          match_q, match_d;
  logic [4:0]    index_q, index_d;
  logic          tmo_q, tmo_d;
  logic [7:0]    mem_q [STR_MAX];

  logic          acc;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [LW-1:0] lim;

  assign in_ready = (state_q == S_IDLE) | (state_q == S_LOAD);
  assign busy     = (state_q != S_IDLE);
  assign res_valid = (state_q == S_RESP);
  assign acc      = in_valid & in_ready;
  assign lim      = type_q ? PAT_LIM : STR_LIM;

  assign sme_chardata  = char_q;
  assign sme_isstring  = isstr_q;
  assign sme_ispattern = ispat_q;
  assign res_match     = match_q;
  assign res_index     = index_q;
  assign res_timeout   = tmo_q;

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    len_d   = len_q;
    idx_d   = idx_q;
    drop_d  = drop_q;
    cnt_d   = cnt_q;
    char_d  = char_q;
    isstr_d = 1'b0;
    ispat_d = 1'b0;
    match_d = match_q;
    index_d = index_q;
    tmo_d   = tmo_q;
    wr_en   = 1'b0;
    wr_addr = len_q[IW-1:0];
    ovf     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (acc) begin
          type_d  = in_type;
          wr_en   = 1'b1;
          wr_addr = '0;
          len_d   = LW'(1);
          drop_d  = 1'b0;
          idx_d   = '0;
          state_d = in_last ? S_SEND : S_LOAD;
        end
      end
      S_LOAD: begin
        if (acc) begin
          if (len_q < lim) begin
            wr_en = 1'b1;
            len_d = len_q + LW'(1);
          end else begin
            drop_d = 1'b1;
          end
          if (in_last) begin
            // the last byte itself may be the one dropped
            ovf     = drop_q | (len_q >= lim);
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (idx_q < len_q) begin
          char_d  = mem_q[idx_q[IW-1:0]];
          isstr_d = ~type_q;
          ispat_d = type_q;
          idx_d   = idx_q + LW'(1);
        end else begin
          cnt_d   = '0;
          // SME keeps the string; only patterns yield a result
          state_d = type_q ? S_WAIT : S_IDLE;
        end
      end
      S_WAIT: begin
        if (sme_valid) begin
          match_d = sme_match;
          index_d = sme_match_index;
          tmo_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == TO_LIM) begin
          match_d = 1'b0;
          index_d = '0;
          tmo_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      type_q  <= 1'b0;
      len_q   <= '0;
      idx_q   <= '0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
      char_q  <= '0;
      isstr_q <= 1'b0;
      ispat_q <= 1'b0;
      match_q <= 1'b0;
      index_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      isstr_q <= isstr_d;
      ispat_q <= ispat_d;
      match_q <= match_d;
      index_q <= index_d;
      tmo_q   <= tmo_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STR_MAX; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= in_char;
    end
  end

endmodule
